ifetch: RTL
===========

Name: ifetch

Overview:
- Instruction fetch stage for the MIPS core.
- Generates the PC, issues requests on the instruction-memory request/response interface, and delivers {instr, pc} to the decode stage with a valid/ready handshake.
- The decode stage drives main-decode and consumes op/funct.
- Accepts a redirect from branch/jump resolution and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  out  1  instruction request valid.
- inst_addr  out  ADDR_W  request byte address; always word aligned.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  response data valid this cycle.
- inst_rdata  in  32  response instruction word.
- id_valid  out  1  {id_instr, id_pc} valid to decode.
- id_ready  in  1  decode accepts this cycle.
- id_instr  out  32  fetched instruction.
- id_pc  out  ADDR_W  address of id_instr.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  target address; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC, state=REQ.
  - inst_req=0 while resetn=0.
  - id_valid=0, id_instr=0, id_pc=0, skid empty, discard=0.
- One outstanding request maximum. Transfers:
  - Request: inst_req & inst_addr_ok.
  - Response: inst_data_ok, which only arrives while in WAIT.
  - Decode: id_valid & id_ready.
- FSM states: REQ, WAIT, FULL.
  - REQ: inst_req=1, inst_addr=pc_q. On inst_addr_ok -> WAIT. inst_req stays high and inst_addr stays stable until accepted, except on redirect.
  - WAIT: inst_req=0. On inst_data_ok:
    - discard=1: drop the word, clear discard, -> REQ.
    - Output register free (id_valid=0 or id_ready=1): load id_instr=inst_rdata, id_pc=pc_q, id_valid=1; pc_q+=4; -> REQ.
    - Otherwise: write the word into the 1-entry skid with pc_q; pc_q+=4; -> FULL.
  - FULL: inst_req=0. When id_ready=1, move skid to the output register the next cycle, empty skid, -> REQ.
- Latency: inst_data_ok in cycle N gives id_valid=1 in cycle N+1. With zero-wait memory (addr_ok same cycle, data_ok next cycle), sustained throughput is 1 instruction per 2 cycles.
- Redirect (redirect_valid=1 in cycle N, highest priority), taking effect at edge N:
  - pc_q=redirect_pc & ~3.
  - id_valid=0; skid emptied.
  - Any same-cycle inst_data_ok word is dropped.
  - If in WAIT with no data_ok this cycle, or in REQ with inst_addr_ok=1: set discard=1 and go to WAIT.
  - Otherwise -> REQ.
  - The decode handshake in cycle N is still honoured, since decode sees the flush the same cycle.
- PC arithmetic: pc_q+4 wraps modulo 2^ADDR_W (FFFF_FFFC -> 0000_0000). No alignment or exception checks here.
- Reset mid-request: all state cleared. Any late inst_data_ok after reset release arrives while in REQ and is ignored.
- Back-to-back redirects: the last one wins; discard stays 1 while a response is outstanding.
- id_instr and id_pc are held stable while id_valid=1 and id_ready=0.

Decomposition:
- Shared package (cpu_defines): RESET_PC, the ifetch state encodings (REQ=2'd0, WAIT=2'd1, FULL=2'd2), and the 32'h0 NOP constant.
- One sub-module, ifetch_skid: a 1-entry {instr, pc} holding buffer with load/drain/flush. The FSM and PC logic stay in ifetch.

Test Plan:
- Reset/first fetch: release resetn -> next cycle inst_req=1, inst_addr=BFC0_0000. With zero-wait memory returning 24080001 -> id_valid=1, id_instr=24080001, id_pc=BFC0_0000; next inst_addr=BFC0_0004.
- Stream: 4 responses with id_ready=1 -> id_pc=BFC0_0000/4/8/C in order, no duplicates or gaps, one instruction every 2 cycles.
- Decode stall: id_ready=0 for 6 cycles after the first output -> second word enters the skid, state FULL, inst_req=0, id_instr held. On id_ready=1 -> skid word delivered next, then fetch resumes at BFC0_0008.
- Redirect while in WAIT: redirect_pc=8000_0103 -> pending response dropped, then inst_addr=8000_0100, id_valid=0 until that word returns with id_pc=8000_0100.
- Redirect coincident with inst_data_ok and with a full skid -> word dropped, id_valid=0 next cycle, skid empty, inst_addr=target.
- Wrap: redirect to FFFF_FFFC, deliver the word -> next inst_addr=0000_0000.
- Async reset asserted in WAIT -> outputs cleared immediately. A late inst_data_ok after release is ignored, and the first id_pc=BFC0_0000.

Source files
------------

// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared constants and encodings for the MIPS core
package cpu_defines;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_FULL = 2'd2
    } if_state_e;

endpackage

// File: rtl/ifetch_skid.sv
// rtl/ifetch_skid.sv - one-entry {instr, pc} holding buffer for the fetch stage
module ifetch_skid #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);
    import cpu_defines::*;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Flush and drain both empty the entry; payload is kept since valid gates it.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush || drain) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC generation, imem requests, decode handoff
module ifetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defines::RESET_PC)
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    import cpu_defines::*;

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              discard_q, discard_d;
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;

    logic              skid_load, skid_drain, skid_flush;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_tgt;

    assign pc_inc       = pc_q + ADDR_W'(4);
    assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

    ifetch_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .load     (skid_load),
        .drain    (skid_drain),
        .flush    (skid_flush),
        .in_instr (inst_rdata),
        .in_pc    (pc_q),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            // A request still in flight must have its response swallowed.
            pc_d       = redirect_tgt;
            id_valid_d = 1'b0;
            skid_flush = 1'b1;
            if ((state_q == IF_WAIT && !inst_data_ok) ||
                (state_q == IF_REQ && inst_addr_ok)) begin
                discard_d = 1'b1;
                state_d   = IF_WAIT;
            end else begin
                discard_d = 1'b0;
                state_d   = IF_REQ;
            end
        end else begin
            case (state_q)
                IF_REQ: begin
                    if (inst_addr_ok) begin
                        state_d = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = IF_REQ;
                        end else if (!id_valid_q || id_ready) begin
                            id_valid_d = 1'b1;
                            id_instr_d = inst_rdata;
                            id_pc_d    = pc_q;
                            pc_d       = pc_inc;
                            state_d    = IF_REQ;
                        end else begin
                            skid_load = 1'b1;
                            pc_d      = pc_inc;
                            state_d   = IF_FULL;
                        end
                    end
                end
                IF_FULL: begin
                    if (id_ready && skid_valid) begin
                        id_valid_d = 1'b1;
                        id_instr_d = skid_instr;
                        id_pc_d    = skid_pc;
                        skid_drain = 1'b1;
                        state_d    = IF_REQ;
                    end
                end
                default: state_d = IF_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IF_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Gate with reset so no request is presented while the core is held.
    assign inst_req  = resetn & (state_q == IF_REQ);
    assign inst_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

endmodule
